counter_reader: RTL and testbench
=================================

COUNTER_READER -- requirements
Module: counter_reader

Interface
REQ-001 Parameter MSB_FIRST, default 0, byte order: 0 = byte 0 (bits 7:0) first, 1 = byte 7 (bits 63:56) first.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req  input  1  start request; sampled only in IDLE.
REQ-005 Slt  input  1  source select sampled with Req: 0 = In0, 1 = In1.
REQ-006 In0  input  64  counter value, channel 0 (select_counter Output0).
REQ-007 In1  input  64  counter value, channel 1 (select_counter Output1).
REQ-008 Dout  output  8  current byte on offer.
REQ-009 Valid  output  1  Dout holds a valid byte.
REQ-010 Ready  input  1  sink accepts; a transfer occurs on a rising edge with Valid && Ready.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Done  output  1  one-cycle pulse after the final byte transfers.

Function
REQ-013 States SHALL be IDLE, SEND, CSUM and DONE; CSUM is reachable only with CHECKSUM_EN defined.
REQ-014 IDLE with Req=1 at edge k: SHALL snapshot (Slt ? In1 : In0) into a 64-bit register, clear the byte index, and enter SEND; Valid=1 with the first byte from cycle k+1.
REQ-015 Changes on In0/In1/Slt after the snapshot SHALL NOT affect the transmitted data.
REQ-016 SEND: Dout SHALL be snapshot byte idx (MSB_FIRST=0) or byte 7-idx (MSB_FIRST=1), idx 0..7.
REQ-017 Dout and Valid SHALL stay stable while Valid && !Ready (no drop, no advance).
REQ-018 Each transfer SHALL increment idx; a transfer at idx=7 SHALL leave SEND (to CSUM or DONE) with no index wrap.
REQ-019 Ready=1 continuously SHALL give back-to-back transfers: 8 bytes in 8 consecutive cycles.
REQ-020 DONE SHALL assert Done=1, Valid=0 and Busy=1 for exactly one cycle, then return to IDLE.
REQ-021 Req in any state other than IDLE SHALL be ignored; Req held high through DONE SHALL start a new transfer at the first IDLE edge.
REQ-022 Valid=0 SHALL give Dout=8'h00.
REQ-023 Ready while Valid=0 SHALL have no effect.

Reset
REQ-024 Reset=1 SHALL immediately force IDLE with Valid=0, Busy=0, Done=0, Dout=8'h00, idx=0 and the snapshot register at 64'h0.
REQ-025 Reset mid-transfer SHALL abort with no Done pulse; the partial frame SHALL NOT resume after release.
REQ-026 First Req sampling SHALL be at the first rising edge after Reset deasserts.

Configuration
REQ-027 Macro COUNTER_READER_CHECKSUM_EN defined: after byte 7, CSUM offers Dout = XOR of the 8 snapshot bytes with Valid=1 under REQ-017; its transfer enters DONE (9 transfers per frame).
REQ-028 Macro undefined: no CSUM state or checksum logic; the byte-7 transfer enters DONE directly (8 transfers per frame).

Verification
REQ-029 MSB_FIRST=0, Slt=0, In0=64'h0123456789ABCDEF, Ready=1, Req pulse -> Dout EF,CD,AB,89,67,45,23,01 on 8 consecutive cycles, then Done pulse for 1 cycle.
REQ-030 MSB_FIRST=1, Slt=1, In1=64'h0123456789ABCDEF, Ready=1 -> Dout 01,23,45,67,89,AB,CD,EF, then Done.
REQ-031 Ready low for 3 cycles on byte 2 -> Dout=AB held with Valid=1 for 4 cycles; the sequence continues unchanged; In0 changed mid-frame has no effect.
REQ-032 Reset pulse after 4 bytes -> Valid=0, Busy=0 at once; no Done; next Req restarts at byte 0.
REQ-033 Req pulsed while Busy -> ignored, exactly one frame sent; Req held high -> second frame starts 1 cycle after Done.
REQ-034 COUNTER_READER_CHECKSUM_EN defined, In0=64'h0123456789ABCDEF -> 9th byte 8'h00 (XOR of the 8 bytes), then Done; In0=64'h00000000000000FF -> 9th byte 8'hFF.

Source files
------------

// File: rtl/counter_reader.sv
// Byte-serial reader: snapshots one of two 64-bit counters and streams it out a byte at a time over a valid/ready handshake.
// Optional trailing XOR checksum byte when COUNTER_READER_CHECKSUM_EN is defined.
module counter_reader #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        slt,
  input  logic [63:0] in0,
  input  logic [63:0] in1,
  output logic [7:0]  dout,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        done
);

`ifdef COUNTER_READER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state, state_nx;
  logic [63:0] snap;
  logic [2:0]  idx;
  logic        load;
  logic        adv;
  logic [2:0]  byte_sel;
  logic [7:0]  data_byte;

  assign byte_sel  = MSB_FIRST ? (3'd7 - idx) : idx;
  assign data_byte = snap[{byte_sel, 3'b000} +: 8];

`ifdef COUNTER_READER_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 8; i++) csum = csum ^ snap[i*8 +: 8];
  end
`endif

  // NOTE: the snapshot register is reset along with the state so a stale counter value is never observable after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      snap  <= 64'h0;
      idx   <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      if (load) begin
        snap <= slt ? in1 : in0;
        idx  <= 3'd0;
      end else if (adv) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    dout     = 8'h00;
    valid    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          load     = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        dout  = data_byte;
        if (ready) begin
          if (idx == 3'd7) begin
`ifdef COUNTER_READER_CHECKSUM_EN
            state_nx = CSUM;
`else
            state_nx = DONE;
`endif
          end else begin
            adv = 1'b1;
          end
        end
      end
`ifdef COUNTER_READER_CHECKSUM_EN
      CSUM: begin
        valid = 1'b1;
        dout  = csum;
        if (ready) state_nx = DONE;
      end
`endif
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_reader.sv
// Bench for counter_reader: two instances (LSB-first and MSB-first) against a frame-queue model plus literal byte sequences.
module tb_counter_reader;

`ifdef COUNTER_READER_CHECKSUM_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req = 1'b0;
  logic        slt = 1'b0;
  logic [63:0] in0 = 64'h0;
  logic [63:0] in1 = 64'h0;
  logic        ready = 1'b0;
  logic [7:0]  dout0, dout1;
  logic        valid0, valid1, busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  int         capcyc0 [$];
  int         donecyc [$];

  counter_reader #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset(reset), .req(req), .slt(slt), .in0(in0), .in1(in1),
    .dout(dout0), .valid(valid0), .ready(ready), .busy(busy0), .done(done0)
  );

  counter_reader #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .req(req), .slt(slt), .in0(in0), .in1(in1),
    .dout(dout1), .valid(valid1), .ready(ready), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a loaded frame is a list of bytes in send order; the head is on offer, a transfer pops it, and an empty list yields one done cycle.
  logic [7:0] m_lsb [0:8];
  logic [7:0] m_msb [0:8];
  int         m_len = 0;
  int         m_pos = 0;
  bit         m_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_len  <= 0;
      m_pos  <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_len == 0) begin
      if (req) begin
        logic [63:0] v;
        logic [7:0]  x;
        v = slt ? in1 : in0;
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
          m_lsb[i] <= v[8*i +: 8];
          m_msb[i] <= v[8*(7-i) +: 8];
          x = x ^ v[8*i +: 8];
        end
        m_lsb[8] <= x;
        m_msb[8] <= x;
        m_len    <= FRAME_LEN;
        m_pos    <= 0;
      end
    end else if (ready) begin
      if (m_pos == m_len - 1) begin
        m_len  <= 0;
        m_done <= 1'b1;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic ev;
    ev = (m_len != 0);
    check("valid0", valid0, ev);
    check("valid1", valid1, ev);
    check("dout0", dout0, ev ? m_lsb[m_pos] : 8'h00);
    check("dout1", dout1, ev ? m_msb[m_pos] : 8'h00);
    check("busy0", busy0, ev || m_done);
    check("busy1", busy1, ev || m_done);
    check("done0", done0, m_done);
    check("done1", done1, m_done);
    if (!reset && valid0 && ready) begin
      cap0.push_back(dout0);
      capcyc0.push_back(cyc);
    end
    if (!reset && valid1 && ready) cap1.push_back(dout1);
    if (done0) begin
      done_cnt <= done_cnt + 1;
      donecyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_req(input logic s);
    step(1);
    req = 1'b1;
    slt = s;
    step(1);
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done0) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_caps(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (cap0.size() >= n) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic check_seq(input string name, input int base);
    logic [7:0] lsb_seq [0:8];
    logic [7:0] msb_seq [0:8];
    lsb_seq = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
    msb_seq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
    check({name, "_len0"}, cap0.size() - base, FRAME_LEN);
    check({name, "_len1"}, cap1.size() - base, FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++) begin
      check($sformatf("%s_lsb%0d", name, i), cap0[base+i], lsb_seq[i]);
      check($sformatf("%s_msb%0d", name, i), cap1[base+i], msb_seq[i]);
    end
  endtask

  initial begin
    int base, dbase;
    reset = 1'b1;
    #7;
    check("rst_valid", valid0, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_dout", dout0, 8'h00);
    step(2);
    reset = 1'b0;
    step(2);

    // Back-to-back frame from in0, both byte orders.
    in0 = 64'h0123456789ABCDEF;
    in1 = 64'hFFEEDDCCBBAA9988;
    ready = 1'b1;
    base = cap0.size();
    pulse_req(1'b0);
    wait_done("a_done");
    check_seq("a", base);
    check("a_back2back", capcyc0[base+FRAME_LEN-1] - capcyc0[base], FRAME_LEN - 1);
    step(2);
    check("a_one_done", done_cnt, 1);

    // Frame from in1.
    in0 = 64'hFFEEDDCCBBAA9988;
    in1 = 64'h0123456789ABCDEF;
    base = cap0.size();
    pulse_req(1'b1);
    wait_done("b_done");
    check_seq("b", base);
    step(2);

    // Ready stalls on byte 2 for three cycles, in0 changes mid-frame.
    in0 = 64'h0123456789ABCDEF;
    slt = 1'b0;
    ready = 1'b0;
    base = cap0.size();
    step(1);
    req = 1'b1;
    step(1);
    req = 1'b0;
    ready = 1'b1;
    step(2);
    ready = 1'b0;
    in0 = 64'h0;
    step(3);
    ready = 1'b1;
    wait_done("c_done");
    check_seq("c", base);
    check("c_hold_ab", capcyc0[base+2] - capcyc0[base+1], 4);
    step(2);

    // Reset after four bytes aborts the frame.
    in0 = 64'h0123456789ABCDEF;
    dbase = done_cnt;
    base = cap0.size();
    pulse_req(1'b0);
    wait_caps("d_four", base + 4);
    step(1);
    reset = 1'b1;
    #1;
    check("d_rst_valid", valid0, 1'b0);
    check("d_rst_busy", busy0, 1'b0);
    step(1);
    reset = 1'b0;
    step(4);
    check("d_no_done", done_cnt - dbase, 0);
    check("d_no_resume", valid0, 1'b0);
    base = cap0.size();
    pulse_req(1'b0);
    wait_done("d_done");
    check_seq("d", base);
    step(2);

    // Req during busy is ignored.
    dbase = done_cnt;
    base = cap0.size();
    pulse_req(1'b0);
    step(3);
    pulse_req(1'b0);
    wait_done("e_done");
    step(4);
    check("e_one_frame", done_cnt - dbase, 1);
    check("e_bytes", cap0.size() - base, FRAME_LEN);
    check("e_idle", busy0, 1'b0);

    // Req held high restarts after one idle cycle.
    base = cap0.size();
    dbase = donecyc.size();
    step(1);
    req = 1'b1;
    wait_done("f_done1");
    wait_caps("f_restart", base + FRAME_LEN + 1);
    req = 1'b0;
    check("f_gap", capcyc0[base+FRAME_LEN] - donecyc[dbase], 2);
    wait_done("f_done2");
    step(4);
    check("f_stop", valid0, 1'b0);

`ifdef COUNTER_READER_CHECKSUM_EN
    in0 = 64'h00000000000000FF;
    base = cap0.size();
    pulse_req(1'b0);
    wait_done("g_done");
    check("g_csum0", cap0[base+8], 8'hFF);
    check("g_csum1", cap1[base+8], 8'hFF);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
